// File: rtl/trap_ctrl.sv
// Trap sequencer between execute and the CSR file: detects synchronous exceptions
// and mret, strobes the CSR capture, then hands a PC redirect to fetch.
module trap_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [31:0]      pc,
  input  logic             is_ecall,
  input  logic             is_ebreak,
  input  logic             is_mret,
  input  logic             is_illegal,
  input  logic [31:0]      mtvec,
  input  logic [31:0]      mepc,
  output logic             exception,
  output logic [31:0]      exception_pc,
  output logic [31:0]      exception_cause,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             stall,
  output logic [CNT_W-1:0] trap_count
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] TRAP     = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  localparam logic [31:0] CAUSE_MISALIGNED = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK     = 32'd3;
  localparam logic [31:0] CAUSE_ECALL      = 32'd11;

  logic [1:0]       state_q, state_d;
  logic [31:0]      exception_pc_q, exception_pc_d;
  logic [31:0]      exception_cause_q, exception_cause_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] trap_count_q, trap_count_d;

  logic             trap_hit;
  logic [31:0]      trap_cause;

  // Priority encode the synchronous exception sources; mret is handled separately.
  always_comb begin
    trap_hit   = 1'b1;
    trap_cause = CAUSE_MISALIGNED;
    if (pc[1:0] != 2'b00) begin
      trap_cause = CAUSE_MISALIGNED;
    end else if (is_illegal) begin
      trap_cause = CAUSE_ILLEGAL;
    end else if (is_ebreak) begin
      trap_cause = CAUSE_EBREAK;
    end else if (is_ecall) begin
      trap_cause = CAUSE_ECALL;
    end else begin
      trap_hit = 1'b0;
    end
  end

  always_comb begin
    state_d           = state_q;
    exception_pc_d    = exception_pc_q;
    exception_cause_d = exception_cause_q;
    redirect_pc_d     = redirect_pc_q;
    trap_count_d      = trap_count_q;
    case (state_q)
      IDLE: begin
        if (inst_valid) begin
          // CSR targets are latched here so later CSR writes cannot move a pending redirect.
          if (trap_hit) begin
            exception_pc_d    = pc;
            exception_cause_d = trap_cause;
            redirect_pc_d     = {mtvec[31:2], 2'b00};
            state_d           = TRAP;
          end else if (is_mret) begin
            redirect_pc_d = {mepc[31:2], 2'b00};
            state_d       = REDIRECT;
          end
        end
      end
      TRAP: begin
        trap_count_d = trap_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d      = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      exception_pc_q    <= '0;
      exception_cause_q <= '0;
      redirect_pc_q     <= '0;
      trap_count_q      <= '0;
    end else begin
      state_q           <= state_d;
      exception_pc_q    <= exception_pc_d;
      exception_cause_q <= exception_cause_d;
      redirect_pc_q     <= redirect_pc_d;
      trap_count_q      <= trap_count_d;
    end
  end

  assign inst_ready      = (state_q == IDLE);
  assign stall           = (state_q != IDLE);
  assign exception       = (state_q == TRAP);
  assign redirect_valid  = (state_q == REDIRECT);
  assign exception_pc    = exception_pc_q;
  assign exception_cause = exception_cause_q;
  assign redirect_pc     = redirect_pc_q;
  assign trap_count      = trap_count_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap/mret sequencing, priority, backpressure,
// target latching, asynchronous reset and counter wrap (CNT_W=4).
module tb_trap_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      pc;
  logic             is_ecall;
  logic             is_ebreak;
  logic             is_mret;
  logic             is_illegal;
  logic [31:0]      mtvec;
  logic [31:0]      mepc;
  logic             exception;
  logic [31:0]      exception_pc;
  logic [31:0]      exception_cause;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ready;
  logic             stall;
  logic [CNT_W-1:0] trap_count;

  int tests_run;
  int tests_failed;

  trap_ctrl #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .pc              (pc),
    .is_ecall        (is_ecall),
    .is_ebreak       (is_ebreak),
    .is_mret         (is_mret),
    .is_illegal      (is_illegal),
    .mtvec           (mtvec),
    .mepc            (mepc),
    .exception       (exception),
    .exception_pc    (exception_pc),
    .exception_cause (exception_cause),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_ready  (redirect_ready),
    .stall           (stall),
    .trap_count      (trap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inst();
    inst_valid = 1'b0;
    is_ecall   = 1'b0;
    is_ebreak  = 1'b0;
    is_mret    = 1'b0;
    is_illegal = 1'b0;
  endtask

  task automatic test_reset();
    clear_inst();
    pc = 32'h0; mtvec = 32'h0; mepc = 32'h0; redirect_ready = 1'b0;
    rst = 1'b1;
    #3;
    tests_run++;
    if (inst_ready !== 1'b1 || stall !== 1'b0 || exception !== 1'b0 || redirect_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: inst_ready=%b stall=%b exception=%b redirect_valid=%b, want 1 0 0 0",
               inst_ready, stall, exception, redirect_valid);
    end
    tests_run++;
    if (exception_pc !== 32'h0 || exception_cause !== 32'h0 || redirect_pc !== 32'h0 || trap_count !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_data: epc=%h cause=%h rpc=%h cnt=%h, want all 0",
               exception_pc, exception_cause, redirect_pc, trap_count);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_ecall();
    mtvec = 32'h8000_0101; pc = 32'h8000_0010; redirect_ready = 1'b1;
    inst_valid = 1'b1; is_ecall = 1'b1;
    step();
    clear_inst();
    tests_run++;
    if (exception !== 1'b1 || stall !== 1'b1 || inst_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ecall_trap_state: exception=%b stall=%b inst_ready=%b, want 1 1 0", exception, stall, inst_ready);
    end
    tests_run++;
    if (exception_cause !== 32'd11 || exception_pc !== 32'h8000_0010) begin
      tests_failed++;
      $display("FAIL ecall_capture: cause=%0d pc=%h, want 11 80000010", exception_cause, exception_pc);
    end
    step();
    tests_run++;
    if (exception !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0100) begin
      tests_failed++;
      $display("FAIL ecall_redirect: exception=%b rv=%b rpc=%h, want 0 1 80000100", exception, redirect_valid, redirect_pc);
    end
    tests_run++;
    if (trap_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL ecall_count: got %0d want 1", trap_count);
    end
    step();
    tests_run++;
    if (inst_ready !== 1'b1 || redirect_valid !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL ecall_return: inst_ready=%b rv=%b stall=%b, want 1 0 0", inst_ready, redirect_valid, stall);
    end
  endtask

  task automatic test_priority();
    logic [31:0] pcs   [3];
    logic [2:0]  flags [3];
    logic [31:0] want  [3];
    pcs[0] = 32'h8000_0002; flags[0] = 3'b111; want[0] = 32'd0;
    pcs[1] = 32'h8000_0004; flags[1] = 3'b111; want[1] = 32'd2;
    pcs[2] = 32'h8000_0008; flags[2] = 3'b011; want[2] = 32'd3;
    redirect_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = pcs[i];
      {is_illegal, is_ebreak, is_ecall} = flags[i];
      inst_valid = 1'b1;
      step();
      clear_inst();
      tests_run++;
      if (exception !== 1'b1 || exception_cause !== want[i] || exception_pc !== pcs[i]) begin
        tests_failed++;
        $display("FAIL priority_%0d: exception=%b cause=%0d pc=%h, want 1 %0d %h",
                 i, exception, exception_cause, exception_pc, want[i], pcs[i]);
      end
      step();
      step();
    end
    tests_run++;
    if (trap_count !== 4'd4) begin
      tests_failed++;
      $display("FAIL priority_count: got %0d want 4", trap_count);
    end
  endtask

  task automatic test_mret();
    mepc = 32'h8000_0014; redirect_ready = 1'b1;
    inst_valid = 1'b1; is_mret = 1'b1;
    step();
    clear_inst();
    tests_run++;
    if (exception !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0014) begin
      tests_failed++;
      $display("FAIL mret_redirect: exception=%b rv=%b rpc=%h, want 0 1 80000014", exception, redirect_valid, redirect_pc);
    end
    tests_run++;
    if (trap_count !== 4'd4 || exception_cause !== 32'd3 || exception_pc !== 32'h8000_0008) begin
      tests_failed++;
      $display("FAIL mret_unchanged: cnt=%0d cause=%0d epc=%h, want 4 3 80000008", trap_count, exception_cause, exception_pc);
    end
    step();
    tests_run++;
    if (inst_ready !== 1'b1 || redirect_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mret_return: inst_ready=%b rv=%b, want 1 0", inst_ready, redirect_valid);
    end
  endtask

  task automatic test_backpressure();
    mtvec = 32'h8000_0200; pc = 32'h8000_0020; redirect_ready = 1'b0;
    inst_valid = 1'b1; is_ecall = 1'b1;
    step();
    clear_inst();
    step();
    for (int i = 0; i < 5; i++) begin
      inst_valid = 1'b1; is_ecall = 1'b1; is_mret = 1'b1; pc = 32'h8000_0030; mepc = 32'h8000_0500;
      step();
      tests_run++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0200 || stall !== 1'b1 ||
          inst_ready !== 1'b0 || exception !== 1'b0 || trap_count !== 4'd5) begin
        tests_failed++;
        $display("FAIL hold_%0d: rv=%b rpc=%h stall=%b ir=%b exc=%b cnt=%0d, want 1 80000200 1 0 0 5",
                 i, redirect_valid, redirect_pc, stall, inst_ready, exception, trap_count);
      end
    end
    clear_inst();
    redirect_ready = 1'b1;
    step();
    tests_run++;
    if (inst_ready !== 1'b1 || redirect_valid !== 1'b0 || exception_pc !== 32'h8000_0020) begin
      tests_failed++;
      $display("FAIL hold_release: ir=%b rv=%b epc=%h, want 1 0 80000020", inst_ready, redirect_valid, exception_pc);
    end
  endtask

  task automatic test_late_csr();
    mtvec = 32'h8000_0300; pc = 32'h8000_0040; redirect_ready = 1'b1;
    inst_valid = 1'b1; is_ebreak = 1'b1;
    step();
    clear_inst();
    mtvec = 32'h0;
    step();
    tests_run++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0300) begin
      tests_failed++;
      $display("FAIL late_csr: rv=%b rpc=%h, want 1 80000300", redirect_valid, redirect_pc);
    end
    step();
  endtask

  task automatic test_back_to_back();
    mepc = 32'h8000_0050; redirect_ready = 1'b1;
    inst_valid = 1'b1; is_mret = 1'b1;
    step();
    is_mret = 1'b0; is_ecall = 1'b1; pc = 32'h8000_0054; mtvec = 32'h8000_0100;
    step();
    tests_run++;
    if (inst_ready !== 1'b1 || exception !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: ir=%b exc=%b, want 1 0", inst_ready, exception);
    end
    step();
    clear_inst();
    tests_run++;
    if (exception !== 1'b1 || exception_pc !== 32'h8000_0054 || exception_cause !== 32'd11) begin
      tests_failed++;
      $display("FAIL b2b_trap: exc=%b epc=%h cause=%0d, want 1 80000054 11", exception, exception_pc, exception_cause);
    end
    step();
    tests_run++;
    if (redirect_pc !== 32'h8000_0100 || trap_count !== 4'd7) begin
      tests_failed++;
      $display("FAIL b2b_redirect: rpc=%h cnt=%0d, want 80000100 7", redirect_pc, trap_count);
    end
    step();
  endtask

  task automatic test_reset_mid_redirect();
    mtvec = 32'h8000_0400; pc = 32'h8000_0060; redirect_ready = 1'b0;
    inst_valid = 1'b1; is_ecall = 1'b1;
    step();
    clear_inst();
    step();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (inst_ready !== 1'b1 || stall !== 1'b0 || exception !== 1'b0 || redirect_valid !== 1'b0 ||
        exception_pc !== 32'h0 || exception_cause !== 32'h0 || redirect_pc !== 32'h0 || trap_count !== 4'h0) begin
      tests_failed++;
      $display("FAIL async_reset: ir=%b stall=%b exc=%b rv=%b epc=%h cause=%h rpc=%h cnt=%0d, want 1 0 0 0 0 0 0 0",
               inst_ready, stall, exception, redirect_valid, exception_pc, exception_cause, redirect_pc, trap_count);
    end
    @(negedge clk);
    rst = 1'b0;
    redirect_ready = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    mtvec = 32'h8000_0000; pc = 32'h8000_0070; redirect_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      inst_valid = 1'b1; is_illegal = 1'b1;
      step();
      clear_inst();
      step();
      if (i == 14) begin
        tests_run++;
        if (trap_count !== 4'd15) begin
          tests_failed++;
          $display("FAIL wrap_15: got %0d want 15", trap_count);
        end
      end
      step();
    end
    tests_run++;
    if (trap_count !== 4'd0 || inst_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_0: cnt=%0d ir=%b, want 0 1", trap_count, inst_ready);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_ecall();
    test_priority();
    test_mret();
    test_backpressure();
    test_late_csr();
    test_back_to_back();
    test_reset_mid_redirect();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
